// File: rtl/nabp_filter_mapper_pkg.sv
// Shared constants and state types for the filtered-projection mapper.
// Widths and helpers are used by the mapper and its bus interface.
package nabp_filter_mapper_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int NO_SAMPLES  = 256;
  localparam int NO_ANGLES   = 180;
  localparam int POS_WIDTH   = 10;
  localparam int ADDR_WIDTH  = 16;

  localparam int ANGLE_WIDTH = $clog2(NO_ANGLES);
  localparam int SAMPLE_BITS = $clog2(NO_SAMPLES);

  localparam logic signed [POS_WIDTH-1:0] N_SAMP_POS =
    POS_WIDTH'(NO_SAMPLES);

  typedef enum logic {
    IDLE_S,
    MAP_S
  } mapper_states;

  typedef enum logic [1:0] {
    SH_IDLE_S,
    SH_KICK_S,
    SH_SHIFT_S,
    SH_DONE_S
  } shifter_states;

  // First RAM word of a projection row.
  function automatic logic [ADDR_WIDTH-1:0] angle_base(
    input logic [ANGLE_WIDTH-1:0] idx
  );
    return ADDR_WIDTH'(idx) * ADDR_WIDTH'(NO_SAMPLES);
  endfunction

endpackage

// File: rtl/nabp_filter_mapper_if.sv
// Mapper bus: shifter controls, filtered RAM port, line buffer feed.
// master is the mapper side, slave is the surrounding fabric.
interface nabp_filter_mapper_if
  import nabp_filter_mapper_pkg::*;
();

  logic                   mp_kick;
  logic                   mp_shift_en;
  logic                   mp_done;
  logic [ANGLE_WIDTH-1:0] sc_angle_idx;
  logic [POS_WIDTH-1:0]   sc_start_pos;
  logic                   sc_reverse;

  logic [ADDR_WIDTH-1:0]  fr_addr;
  logic                   fr_en;
  logic [DATA_WIDTH-1:0]  fr_data;

  logic [DATA_WIDTH-1:0]  lb_val;
  logic                   lb_val_valid;
  logic                   busy;

  modport master (
    input  mp_kick,
    input  mp_shift_en,
    input  mp_done,
    input  sc_angle_idx,
    input  sc_start_pos,
    input  sc_reverse,
    output fr_addr,
    output fr_en,
    input  fr_data,
    output lb_val,
    output lb_val_valid,
    output busy
  );

  modport slave (
    output mp_kick,
    output mp_shift_en,
    output mp_done,
    output sc_angle_idx,
    output sc_start_pos,
    output sc_reverse,
    input  fr_addr,
    input  fr_en,
    output fr_data,
    input  lb_val,
    input  lb_val_valid,
    input  busy
  );

endinterface

// File: rtl/nabp_filter_mapper.sv
// Filtered-projection address generator and sample fetcher.
// Out-of-detector positions are zero-filled for the line buffer.
module nabp_filter_mapper
  import nabp_filter_mapper_pkg::*;
(
  input  logic clk,
  input  logic reset,
  nabp_filter_mapper_if.master bus
);

  mapper_states state_q, state_d;

  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic [ADDR_WIDTH-1:0]       base_q, base_d;
  logic                        rev_q, rev_d;
  logic                        shift_q, shift_d;
  logic                        rng_q, rng_d;
  logic [DATA_WIDTH-1:0]       hold_q, hold_d;

  logic                        map_w;
  logic                        in_range;
  logic                        rd;
  logic signed [POS_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0]       lb_now;

  assign map_w    = (state_q == MAP_S);
  assign in_range = !pos_q[POS_WIDTH-1] && (pos_q < N_SAMP_POS);
  assign rd       = map_w && bus.mp_shift_en && !bus.mp_kick;
  assign step     = rev_q ? '1 : POS_WIDTH'(1);

  assign bus.fr_en   = rd && in_range;
  assign bus.fr_addr = base_q +
    ADDR_WIDTH'(pos_q[SAMPLE_BITS-1:0]);

  // Fresh sample on the cycle after a shift, otherwise the last one.
  assign lb_now = shift_q ? (rng_q ? bus.fr_data : '0) : hold_q;

  assign bus.lb_val       = lb_now;
  assign bus.lb_val_valid = shift_q;
  assign bus.busy         = map_w;

  // Next state: a kick always relatches, shifts step the position.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    base_d  = base_q;
    rev_d   = rev_q;
    shift_d = rd;
    rng_d   = in_range;
    hold_d  = lb_now;
    unique case (1'b1)
      bus.mp_kick: begin
        state_d = MAP_S;
        pos_d   = bus.sc_start_pos;
        base_d  = angle_base(bus.sc_angle_idx);
        rev_d   = bus.sc_reverse;
      end
      (!bus.mp_kick && map_w): begin
        if (bus.mp_shift_en) pos_d = pos_q + step;
        if (bus.mp_done) state_d = IDLE_S;
      end
      default: ;
    endcase
  end

  // State and one-cycle read pipe; reset drops any in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_S;
      pos_q   <= '0;
      base_q  <= '0;
      rev_q   <= 1'b0;
      shift_q <= 1'b0;
      rng_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      base_q  <= base_d;
      rev_q   <= rev_d;
      shift_q <= shift_d;
      rng_q   <= rng_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_nabp_filter_mapper.sv
// Bench for nabp_filter_mapper: directed line scenarios plus random
// kick/shift/done traffic against a position/row reference model.
module tb_nabp_filter_mapper;
  import nabp_filter_mapper_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nabp_filter_mapper_if bus ();

  nabp_filter_mapper dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_WIDTH-1:0] ram [NO_ANGLES*NO_SAMPLES];

  int checks = 0;
  int failures = 0;

  bit                    m_busy;
  int                    m_base;
  int                    m_pos;
  int                    m_step;
  logic [DATA_WIDTH-1:0] m_lb;
  bit                    m_valid;

  // RAM with one-cycle read; garbage when not enabled.
  always @(posedge clk)
    bus.fr_data <= bus.fr_en ? ram[int'(bus.fr_addr)]
                             : DATA_WIDTH'($urandom);

  function automatic int wrap(input int p);
    int m;
    int r;
    m = 1 << POS_WIDTH;
    r = ((p % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_base  = 0;
    m_pos   = 0;
    m_step  = 1;
    m_lb    = '0;
    m_valid = 0;
  endtask

  // One clock: drive at negedge, check fetch side, then delivery.
  task automatic cyc(input bit k, input bit s, input bit d,
                     input int ang, input int start,
                     input bit rev);
    bit rdx;
    bit inr;
    bus.mp_kick      = k;
    bus.mp_shift_en  = s;
    bus.mp_done      = d;
    bus.sc_angle_idx = ANGLE_WIDTH'(ang);
    bus.sc_start_pos = POS_WIDTH'(start);
    bus.sc_reverse   = rev;
    #1;
    rdx = m_busy && s && !k;
    inr = (m_pos >= 0) && (m_pos < NO_SAMPLES);
    chk("fr_en", 32'(bus.fr_en), 32'(rdx && inr));
    if (rdx && inr)
      chk("fr_addr", 32'(bus.fr_addr), m_base + m_pos);
    chk("busy", 32'(bus.busy), 32'(m_busy));
    @(posedge clk);
    if (rdx) begin
      m_valid = 1;
      m_lb = inr ? ram[m_base + m_pos] : '0;
    end else begin
      m_valid = 0;
    end
    if (k) begin
      m_busy = 1;
      m_base = ang * NO_SAMPLES;
      m_pos  = start;
      m_step = rev ? -1 : 1;
    end else if (m_busy) begin
      if (s) m_pos = wrap(m_pos + m_step);
      if (d) m_busy = 0;
    end
    @(negedge clk);
    chk("lb_val_valid", 32'(bus.lb_val_valid), 32'(m_valid));
    chk("lb_val", 32'(bus.lb_val), 32'(m_lb));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fr_addr"}, 32'(bus.fr_addr), 0);
    chk({tag, "_fr_en"}, 32'(bus.fr_en), 0);
    chk({tag, "_lb_val"}, 32'(bus.lb_val), 0);
    chk({tag, "_lb_valid"}, 32'(bus.lb_val_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int a;
    for (int i = 0; i < NO_ANGLES * NO_SAMPLES; i++)
      ram[i] = DATA_WIDTH'($urandom);
    reset            = 1'b1;
    bus.mp_kick      = 1'b0;
    bus.mp_shift_en  = 1'b0;
    bus.mp_done      = 1'b0;
    bus.sc_angle_idx = '0;
    bus.sc_start_pos = '0;
    bus.sc_reverse   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Angle 3 forward from 0: rows 768..771.
    cyc(1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Leading edge zero-fill.
    a = int'($urandom_range(0, NO_ANGLES - 1));
    cyc(1, 0, 0, a, -2, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);

    // Reverse from the last sample, then past the end.
    a = int'($urandom_range(0, NO_ANGLES - 1));
    cyc(1, 0, 0, a, 255, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, a, 256, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);

    // Gapped shifts hold lb_val.
    a = int'($urandom_range(0, NO_ANGLES - 1));
    cyc(1, 0, 0, a, 10, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);

    // Done with the final shift, later shifts ignored.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);

    // Kick with shift: kick wins.
    a = int'($urandom_range(0, NO_ANGLES - 1));
    cyc(1, 1, 0, a, 100, 0);
    cyc(1, 1, 0, a, 50, 1);
    cyc(0, 1, 0, 0, 0, 0);

    // Position wrap both directions.
    cyc(1, 0, 0, a, 510, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, a, -511, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);

    // Reset with a read in flight.
    a = int'($urandom_range(0, NO_ANGLES - 1));
    cyc(1, 0, 0, a, 5, 0);
    cyc(0, 1, 0, 0, 0, 0);
    bus.mp_kick     = 1'b0;
    bus.mp_shift_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    bus.mp_shift_en = 1'b0;
    model_reset();
    chk_zero("postreset");
    a = int'($urandom_range(0, NO_ANGLES - 1));
    cyc(1, 0, 0, a, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 12) == 0,
          ($urandom % 3) != 0,
          ($urandom % 20) == 0,
          int'($urandom_range(0, NO_ANGLES - 1)),
          int'($urandom_range(0, 799)) - 300,
          1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
